// File: rtl/cmd_arbiter.sv
//------------------------------------------------------------------------------
// cmd_arbiter: round-robin arbiter feeding two requesters' commands to one UART
// command transmitter. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmd_arbiter #(
  parameter int TMO_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        tmo0,
  output logic        tmo1,
  output logic        snd_cmd,
  output logic [15:0] cmd,
  input  logic        cmd_cmplt,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(TMO_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state;
  logic               ptr;
  logic               gnt_id;
  logic               cmplt_ff;
  logic [CNT_W-1:0]   cnt;

  logic any_req;
  logic win;
  logic rise;

  assign any_req = req0 | req1;
  // With both requesting the pointer decides; otherwise the lone requester wins.
  assign win     = (req0 & req1) ? ptr : req1;
  assign rise    = cmd_cmplt & ~cmplt_ff;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt_id   <= 1'b0;
      cmd      <= 16'h0000;
      cnt      <= '0;
      cmplt_ff <= 1'b0;
      snd_cmd  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      tmo0     <= 1'b0;
      tmo1     <= 1'b0;
    end else begin
      cmplt_ff <= cmd_cmplt;
      snd_cmd  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      tmo0     <= 1'b0;
      tmo1     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= SEND;
            gnt_id  <= win;
            ptr     <= ~win;
            cmd     <= win ? cmd1 : cmd0;
            snd_cmd <= 1'b1;
            ack0    <= ~win;
            ack1    <= win;
          end
        end
        SEND: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          // A completion edge takes precedence over a coincident timeout.
          if (rise) begin
            done0 <= ~gnt_id;
            done1 <= gnt_id;
            state <= IDLE;
          end else if (cnt == TMO_LAST) begin
            tmo0  <= ~gnt_id;
            tmo1  <= gnt_id;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_arbiter.sv
//------------------------------------------------------------------------------
// tb_cmd_arbiter: directed bench with an event scoreboard for cmd_arbiter.
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmd_arbiter;

  localparam int K_ACK  = 1;
  localparam int K_DONE = 2;
  localparam int K_TMO  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, cmd_cmplt;
  logic [15:0] cmd0, cmd1;
  logic        ack0, ack1, done0, done1, tmo0, tmo1, snd_cmd, busy;
  logic [15:0] cmd;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb_q[$];

  cmd_arbiter #(.TMO_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .tmo0(tmo0), .tmo1(tmo1), .snd_cmd(snd_cmd), .cmd(cmd),
    .cmd_cmplt(cmd_cmplt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ev(input int kind, input logic snd, input logic id,
                                     input logic [15:0] c);
    return {4'(kind), 3'b000, snd, 3'b000, id, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      int n;
      logic [31:0] obs;
      logic [31:0] exp;
      n = int'(ack0) + int'(ack1) + int'(done0) + int'(done1) + int'(tmo0) + int'(tmo1);
      if (n > 0) begin
        chk("pulse_onehot", 32'(n), 32'd1);
        if (ack0 | ack1)        obs = ev(K_ACK, snd_cmd, ack1, cmd);
        else if (done0 | done1) obs = ev(K_DONE, snd_cmd, done1, 16'h0);
        else                    obs = ev(K_TMO, snd_cmd, tmo1, 16'h0);
        chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          chk("sb_event", obs, exp);
        end
      end else if (snd_cmd) begin
        chk("snd_without_ack", 32'(snd_cmd), 32'd0);
      end
    end
  end

  task automatic grant(input logic id, input logic [15:0] c);
    sb_q.push_back(ev(K_ACK, 1'b1, id, c));
    tick();
    chk("grant_ack", 32'(id ? ack1 : ack0), 32'd1);
    chk("grant_snd", 32'(snd_cmd), 32'd1);
    chk("grant_cmd", 32'(cmd), 32'(c));
    chk("grant_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_done(input logic id);
    cmd_cmplt = 1'b1;
    sb_q.push_back(ev(K_DONE, 1'b0, id, 16'h0));
    tick();
    chk("done_pulse", 32'(id ? done1 : done0), 32'd1);
    chk("done_idle", 32'(busy), 32'd0);
    cmd_cmplt = 1'b0;
  endtask

  task automatic transact(input logic id, input logic [15:0] c, input int wait_n);
    grant(id, c);
    tick();
    chk("wait_snd_low", 32'(snd_cmd), 32'd0);
    repeat (wait_n) begin
      tick();
      chk("wait_cmd_hold", 32'(cmd), 32'(c));
    end
    finish_done(id);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cmd_cmplt = 1'b0;
    cmd0 = 16'h0; cmd1 = 16'h0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_outs", 32'({ack0, ack1, done0, done1, tmo0, tmo1, snd_cmd}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Request withdrawn before it is ever sampled.
    req0 = 1'b1; #2 req0 = 1'b0;
    tick();
    chk("withdraw_busy", 32'(busy), 32'd0);

    // Single requester, basic transaction.
    req0 = 1'b1; cmd0 = 16'hA55A;
    grant(1'b0, 16'hA55A);
    req0 = 1'b0;
    tick();
    chk("basic_snd_low", 32'(snd_cmd), 32'd0);
    tick();
    tick();
    finish_done(1'b0);
    tick();
    chk("basic_done_once", 32'(done0), 32'd0);

    // Simultaneous requests after reset: 0, then 1, then 0 again.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h1111; cmd1 = 16'h2222;
    transact(1'b0, 16'h1111, 2);
    transact(1'b1, 16'h2222, 1);
    transact(1'b0, 16'h1111, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // Request during WAIT is held off and the captured word stays put.
    req0 = 1'b1; cmd0 = 16'h3333;
    grant(1'b0, 16'h3333);
    req0 = 1'b0;
    tick();
    req1 = 1'b1; cmd1 = 16'h4444;
    repeat (2) begin
      tick();
      chk("hold_cmd", 32'(cmd), 32'h3333);
      chk("hold_no_ack1", 32'(ack1), 32'd0);
    end
    cmd1 = 16'h5555;
    tick();
    chk("hold_cmd_late", 32'(cmd), 32'h3333);
    finish_done(1'b0);
    grant(1'b1, 16'h5555);
    req1 = 1'b0;
    tick();
    finish_done(1'b1);

    // Timeout after 16 WAIT cycles with no completion.
    req0 = 1'b1; cmd0 = 16'h7777;
    grant(1'b0, 16'h7777);
    req0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("tmo_not_yet", 32'({tmo0, busy}), 32'b01);
    end
    sb_q.push_back(ev(K_TMO, 1'b0, 1'b0, 16'h0));
    tick();
    chk("tmo_pulse", 32'({tmo0, done0, busy}), 32'b100);
    tick();
    chk("tmo_single", 32'(tmo0), 32'd0);

    // Completion edge coinciding with the timeout: done wins.
    req1 = 1'b1; cmd1 = 16'hBEEF;
    grant(1'b1, 16'hBEEF);
    req1 = 1'b0;
    repeat (16) tick();
    finish_done(1'b1);
    chk("tie_no_tmo", 32'(tmo1), 32'd0);

    // Completion level stale-high at grant: only a fresh edge counts.
    cmd_cmplt = 1'b1;
    tick();
    req0 = 1'b1; cmd0 = 16'h6666;
    grant(1'b0, 16'h6666);
    req0 = 1'b0;
    tick();
    repeat (3) begin
      tick();
      chk("stale_no_done", 32'({done0, busy}), 32'b01);
    end
    cmd_cmplt = 1'b0;
    tick();
    finish_done(1'b0);

    // Asynchronous reset mid-WAIT aborts silently.
    req0 = 1'b1; cmd0 = 16'h8888;
    grant(1'b0, 16'h8888);
    req0 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cmd", 32'(cmd), 32'h0);
    chk("arst_outs", 32'({ack0, ack1, done0, done1, tmo0, tmo1, snd_cmd}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    req1 = 1'b1; cmd1 = 16'h9999;
    grant(1'b1, 16'h9999);
    req1 = 1'b0;
    tick();
    finish_done(1'b1);

    tick();
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
